clct_pid_readout_fifo: RTL and testbench

- Downstream consumer of the combined 5-bit CLCT pattern ID produced by the pattern-ID encoder.
- Per strobed bunch crossing, tags the 5-bit code with the local BXN and buffers it in a small FIFO.
- On readout, presents the code decoded back into lct0/lct1 valid flags and 3-bit pattern IDs.
- Sits between the CLCT pattern-ID encoder and the DAQ header builder.

---
 rtl/clct_pid_pkg.sv | 20 ++
 rtl/clct_pid_readout_fifo_if.sv | 36 +++
 rtl/pid_decode_5bits.sv | 27 ++
 rtl/clct_pid_readout_fifo.sv | 100 ++++++++++
 tb/tb_clct_pid_readout_fifo.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/clct_pid_pkg.sv
// Shared constants and types for the CLCT pattern-ID readout path.
// The 5-bit code packs lct0-only (0..4), dual (5..29, radix 5), lct1-only (30) and none (31).
package clct_pid_pkg;

  localparam int unsigned PID_SINGLE_MAX = 4;
  localparam int unsigned PID_DUAL_BASE  = 5;
  localparam int unsigned PID_RADIX      = 5;
  localparam int unsigned PID_LCT1_ONLY  = 30;
  localparam int unsigned PID_NONE       = 31;

  typedef logic [4:0] pid_t;

  typedef struct packed {
    logic       lct0_vpf;
    logic       lct1_vpf;
    logic [2:0] pid0;
    logic [2:0] pid1;
  } pid_dec_t;

endpackage

// File: rtl/clct_pid_readout_fifo_if.sv
// Write/readout bundle between the pattern-ID encoder, the readout FIFO and the DAQ header builder.
interface clct_pid_readout_fifo_if #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned BXN_WIDTH = 12,
  parameter int unsigned OVF_WIDTH = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                 clct_pid_we;
  logic [4:0]           clct_pid;
  logic                 bxn_clear;
  logic                 rd_ready;
  logic                 rd_valid;
  logic [4:0]           rd_pid;
  logic [BXN_WIDTH-1:0] rd_bxn;
  logic                 rd_lct0_vpf;
  logic                 rd_lct1_vpf;
  logic [2:0]           rd_pid0;
  logic [2:0]           rd_pid1;
  logic [CNT_W-1:0]     fifo_wdcnt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [OVF_WIDTH-1:0] ovf_cnt;

  modport slave (
    input  clct_pid_we, clct_pid, bxn_clear, rd_ready,
    output rd_valid, rd_pid, rd_bxn, rd_lct0_vpf, rd_lct1_vpf, rd_pid0, rd_pid1,
           fifo_wdcnt, fifo_full, fifo_empty, ovf_cnt
  );

  modport master (
    output clct_pid_we, clct_pid, bxn_clear, rd_ready,
    input  rd_valid, rd_pid, rd_bxn, rd_lct0_vpf, rd_lct1_vpf, rd_pid0, rd_pid1,
           fifo_wdcnt, fifo_full, fifo_empty, ovf_cnt
  );
endinterface

// File: rtl/pid_decode_5bits.sv
// Combinational decode of the combined 5-bit CLCT code back into per-LCT valid flags and pattern IDs.
module pid_decode_5bits
  import clct_pid_pkg::*;
(
  input  pid_t     pid_i,
  output pid_dec_t dec_o
);

  logic [4:0] dual;

  always_comb begin
    dec_o = '0;
    dual  = pid_i - 5'(PID_DUAL_BASE);
    if (pid_i <= 5'(PID_SINGLE_MAX)) begin
      dec_o.lct0_vpf = 1'b1;
      dec_o.pid0     = pid_i[2:0];
    end else if (pid_i < 5'(PID_LCT1_ONLY)) begin
      dec_o.lct0_vpf = 1'b1;
      dec_o.lct1_vpf = 1'b1;
      dec_o.pid0     = 3'(dual % 5'(PID_RADIX));
      dec_o.pid1     = 3'(dual / 5'(PID_RADIX));
    end else if (pid_i != 5'(PID_NONE)) begin
      dec_o.lct1_vpf = 1'b1;
    end
  end

endmodule

// File: rtl/clct_pid_readout_fifo.sv
// BXN-tagged show-ahead FIFO for CLCT pattern-ID codes with decoded readout.
// Optional: define CLCT_PID_SKIP_EMPTY_EN to discard code-31 (no LCT) writes.
module clct_pid_readout_fifo
  import clct_pid_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned BXN_WIDTH = 12,
  parameter int unsigned BXN_MAX   = 3563,
  parameter int unsigned OVF_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   global_reset_n,
  clct_pid_readout_fifo_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [BXN_WIDTH-1:0] bxn;
    pid_t                 pid;
  } entry_t;

  entry_t               mem_q [DEPTH];
  entry_t               head_q, head_d, new_entry;
  logic                 valid_q, valid_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BXN_WIDTH-1:0] bxn_q, bxn_d;
  logic [OVF_WIDTH-1:0] ovf_q, ovf_d;
  logic                 wr_req, pop, push;
  pid_dec_t             dec;

`ifdef CLCT_PID_SKIP_EMPTY_EN
  assign wr_req = bus.clct_pid_we && (bus.clct_pid != pid_t'(PID_NONE));
`else
  assign wr_req = bus.clct_pid_we;
`endif

  assign pop       = valid_q && bus.rd_ready;
  assign push      = wr_req && ((cnt_q != CW'(DEPTH)) || pop);
  assign new_entry = '{bxn: bxn_q, pid: bus.clct_pid};

  always_comb begin
    bxn_d    = (bus.bxn_clear || (bxn_q == BXN_WIDTH'(BXN_MAX))) ? '0 : bxn_q + 1'b1;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    ovf_d    = (wr_req && !push && (ovf_q != '1)) ? ovf_q + 1'b1 : ovf_q;
    valid_d  = (cnt_d != '0);
    head_d   = '0;
    // Head register mirrors mem[rd_ptr]; bypass the write when the new entry becomes head.
    if (valid_d) begin
      head_d = (push && ((cnt_q - CW'(pop)) == '0)) ? new_entry : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      bxn_q    <= '0;
      ovf_q    <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      bxn_q    <= bxn_d;
      ovf_q    <= ovf_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  pid_decode_5bits u_decode (
    .pid_i (head_q.pid),
    .dec_o (dec)
  );

  // Code 0 decodes as a valid lct0, so flags are gated to keep an empty FIFO all-zero.
  assign bus.rd_valid    = valid_q;
  assign bus.rd_pid      = head_q.pid;
  assign bus.rd_bxn      = head_q.bxn;
  assign bus.rd_lct0_vpf = valid_q & dec.lct0_vpf;
  assign bus.rd_lct1_vpf = valid_q & dec.lct1_vpf;
  assign bus.rd_pid0     = valid_q ? dec.pid0 : '0;
  assign bus.rd_pid1     = valid_q ? dec.pid1 : '0;
  assign bus.fifo_wdcnt  = cnt_q;
  assign bus.fifo_full   = (cnt_q == CW'(DEPTH));
  assign bus.fifo_empty  = (cnt_q == '0);
  assign bus.ovf_cnt     = ovf_q;

endmodule

// File: tb/tb_clct_pid_readout_fifo.sv
// Bench for clct_pid_readout_fifo: queue-based reference model checked every cycle plus directed literal checks.
module tb_clct_pid_readout_fifo;

  localparam int unsigned DEPTH     = 16;
  localparam int unsigned BXN_WIDTH = 12;
  localparam int unsigned BXN_MAX   = 3563;
  localparam int unsigned OVF_WIDTH = 8;

  logic clock = 1'b0;
  logic global_reset_n;
  always #5 clock = ~clock;

  clct_pid_readout_fifo_if #(.DEPTH(DEPTH), .BXN_WIDTH(BXN_WIDTH), .OVF_WIDTH(OVF_WIDTH)) bus ();

  clct_pid_readout_fifo #(
    .DEPTH     (DEPTH),
    .BXN_WIDTH (BXN_WIDTH),
    .BXN_MAX   (BXN_MAX),
    .OVF_WIDTH (OVF_WIDTH)
  ) dut (
    .clock          (clock),
    .global_reset_n (global_reset_n),
    .bus            (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of {bxn, code}; the head of the queue is what readout shows.
  typedef struct { int bxn; int pid; } ment_t;
  ment_t mq[$];
  int    m_bxn = 0;
  int    m_ovf = 0;
  bit    m_pop, m_req, m_acc;
  ment_t m_e;

  // Spec decode rules, returned as {vpf0, vpf1, pid0[2:0], pid1[2:0]}.
  function automatic logic [7:0] model_dec(input int v);
    if (v <= 4)       return {1'b1, 1'b0, 3'(v), 3'd0};
    else if (v <= 29) return {1'b1, 1'b1, 3'((v - 5) % 5), 3'((v - 5) / 5)};
    else if (v == 30) return {1'b0, 1'b1, 3'd0, 3'd0};
    else              return 8'd0;
  endfunction

  always @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      mq.delete();
      m_bxn = 0;
      m_ovf = 0;
    end else begin
      m_pop = (mq.size() > 0) && bus.rd_ready;
      m_req = bus.clct_pid_we;
`ifdef CLCT_PID_SKIP_EMPTY_EN
      if (bus.clct_pid == 5'd31) m_req = 1'b0;
`endif
      m_acc   = m_req && ((mq.size() < DEPTH) || m_pop);
      m_e.bxn = m_bxn;
      m_e.pid = int'(bus.clct_pid);
      if (m_pop) void'(mq.pop_front());
      if (m_acc) mq.push_back(m_e);
      else if (m_req && m_ovf < 255) m_ovf++;
      m_bxn = (bus.bxn_clear || m_bxn == BXN_MAX) ? 0 : m_bxn + 1;
    end
  end

  logic [7:0] c_dec;
  int         c_pid, c_bxn;

  always @(negedge clock) begin
    c_pid = 0;
    c_bxn = 0;
    c_dec = 8'd0;
    if (mq.size() > 0) begin
      c_pid = mq[0].pid;
      c_bxn = mq[0].bxn;
      c_dec = model_dec(c_pid);
    end
    chk("m_rd_valid", bus.rd_valid, mq.size() > 0);
    chk("m_rd_pid",   bus.rd_pid, c_pid);
    chk("m_rd_bxn",   bus.rd_bxn, c_bxn);
    chk("m_vpf0",     bus.rd_lct0_vpf, c_dec[7]);
    chk("m_vpf1",     bus.rd_lct1_vpf, c_dec[6]);
    chk("m_pid0",     bus.rd_pid0, c_dec[5:3]);
    chk("m_pid1",     bus.rd_pid1, c_dec[2:0]);
    chk("m_wdcnt",    bus.fifo_wdcnt, mq.size());
    chk("m_full",     bus.fifo_full, mq.size() == DEPTH);
    chk("m_empty",    bus.fifo_empty, mq.size() == 0);
    chk("m_ovf",      bus.ovf_cnt, m_ovf);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int codes [5]  = '{5, 29, 17, 30, 31};
  int e_pid0 [5] = '{0, 4, 2, 0, 0};
  int e_pid1 [5] = '{0, 4, 2, 0, 0};
  int e_vpf0 [5] = '{1, 1, 1, 0, 0};
  int e_vpf1 [5] = '{1, 1, 1, 1, 0};

  initial begin
    global_reset_n    = 1'b0;
    bus.clct_pid_we   = 1'b0;
    bus.clct_pid      = '0;
    bus.bxn_clear     = 1'b0;
    bus.rd_ready      = 1'b0;
    tick();
    tick();
    chk("rst_valid", bus.rd_valid, 0);
    chk("rst_empty", bus.fifo_empty, 1);
    chk("rst_full",  bus.fifo_full, 0);
    chk("rst_wdcnt", bus.fifo_wdcnt, 0);
    chk("rst_vpf0",  bus.rd_lct0_vpf, 0);
    global_reset_n = 1'b1;

    // Single push of code 3 tagged with BXN 10
    bus.bxn_clear = 1'b1;
    tick();
    bus.bxn_clear = 1'b0;
    repeat (10) tick();
    bus.clct_pid_we = 1'b1;
    bus.clct_pid    = 5'd3;
    bus.rd_ready    = 1'b1;
    tick();
    bus.clct_pid_we = 1'b0;
    chk("t1_valid", bus.rd_valid, 1);
    chk("t1_bxn",   bus.rd_bxn, 10);
    chk("t1_vpf0",  bus.rd_lct0_vpf, 1);
    chk("t1_vpf1",  bus.rd_lct1_vpf, 0);
    chk("t1_pid0",  bus.rd_pid0, 3);
    tick();
    chk("t1_empty", bus.fifo_empty, 1);

    // Back-to-back decode sweep through every code range
    for (int i = 0; i < 5; i++) begin
      bus.clct_pid_we = 1'b1;
      bus.clct_pid    = 5'(codes[i]);
      tick();
      chk("t2_pid0", bus.rd_pid0, e_pid0[i]);
      chk("t2_pid1", bus.rd_pid1, e_pid1[i]);
      chk("t2_vpf0", bus.rd_lct0_vpf, e_vpf0[i]);
      chk("t2_vpf1", bus.rd_lct1_vpf, e_vpf1[i]);
    end
    bus.clct_pid_we = 1'b0;
    tick();

    // Overfill: 20 writes into 16 entries
    bus.rd_ready  = 1'b0;
    bus.bxn_clear = 1'b1;
    tick();
    bus.bxn_clear = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.clct_pid_we = 1'b1;
      bus.clct_pid    = 5'(i);
      tick();
      if (i == 14) chk("t3_full_at15", bus.fifo_full, 0);
      if (i == 15) chk("t3_full_at16", bus.fifo_full, 1);
    end
    chk("t3_ovf",   bus.ovf_cnt, 4);
    chk("t3_wdcnt", bus.fifo_wdcnt, 16);

    // Push and pop together while full
    bus.clct_pid    = 5'd21;
    bus.rd_ready    = 1'b1;
    tick();
    bus.clct_pid_we = 1'b0;
    chk("t4_ovf",   bus.ovf_cnt, 4);
    chk("t4_wdcnt", bus.fifo_wdcnt, 16);
    chk("t4_full",  bus.fifo_full, 1);

    for (int j = 0; j < 16; j++) begin
      chk("t4_drain_pid", bus.rd_pid, (j < 15) ? j + 1 : 21);
      chk("t4_drain_bxn", bus.rd_bxn, (j < 15) ? j + 1 : 20);
      tick();
    end
    chk("t4_empty", bus.fifo_empty, 1);

    // BXN wrap at BXN_MAX
    bus.rd_ready  = 1'b0;
    bus.bxn_clear = 1'b1;
    tick();
    bus.bxn_clear = 1'b0;
    repeat (3563) tick();
    bus.clct_pid_we = 1'b1;
    bus.clct_pid    = 5'd7;
    tick();
    bus.clct_pid    = 5'd8;
    tick();
    bus.clct_pid_we = 1'b0;
    chk("t5_bxn_max", bus.rd_bxn, 3563);
    chk("t5_pid_a",   bus.rd_pid, 7);
    bus.rd_ready = 1'b1;
    tick();
    chk("t5_bxn_wrap", bus.rd_bxn, 0);
    chk("t5_pid_b",    bus.rd_pid, 8);
    tick();

    // bxn_clear at BXN 100
    bus.bxn_clear = 1'b1;
    tick();
    bus.bxn_clear = 1'b0;
    repeat (100) tick();
    bus.bxn_clear = 1'b1;
    tick();
    bus.bxn_clear   = 1'b0;
    bus.clct_pid_we = 1'b1;
    bus.clct_pid    = 5'd9;
    tick();
    bus.clct_pid_we = 1'b0;
    chk("t5_clear_bxn", bus.rd_bxn, 0);
    chk("t5_clear_pid", bus.rd_pid, 9);
    tick();

    // Reset with entries queued and overflow count nonzero
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.clct_pid_we = 1'b1;
      bus.clct_pid    = 5'(10 + i);
      tick();
    end
    bus.clct_pid_we = 1'b0;
    chk("t6_pre_wdcnt", bus.fifo_wdcnt, 5);
    chk("t6_pre_ovf",   bus.ovf_cnt, 4);
    #3 global_reset_n = 1'b0;
    #1;
    chk("t6_valid", bus.rd_valid, 0);
    chk("t6_wdcnt", bus.fifo_wdcnt, 0);
    chk("t6_ovf",   bus.ovf_cnt, 0);
    chk("t6_empty", bus.fifo_empty, 1);
    chk("t6_pid",   bus.rd_pid, 0);
    tick();
    tick();
    global_reset_n = 1'b1;

    // Code 31 handling
    bus.clct_pid_we = 1'b1;
    bus.clct_pid    = 5'd31;
    tick();
    bus.clct_pid_we = 1'b0;
`ifdef CLCT_PID_SKIP_EMPTY_EN
    chk("t7_wdcnt_skip", bus.fifo_wdcnt, 0);
`else
    chk("t7_wdcnt_keep", bus.fifo_wdcnt, 1);
    chk("t7_pid_keep",   bus.rd_pid, 31);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
